// File: rtl/cart_pkg.sv
// Shared constants and types for the cartridge bus arbiter.
// Requester indices, FSM encoding and starvation counter width.
package cart_pkg;

  localparam logic [1:0] REQ_CPU  = 2'd0;
  localparam logic [1:0] REQ_HDMA = 2'd1;
  localparam logic [1:0] REQ_OAM  = 2'd2;

  localparam int NREQ  = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/cart_arb_pick.sv
// Winner select: OAM DMA > HDMA > CPU,
// overridden by the starvation flag in favour of a pending CPU.
module cart_arb_pick
  import cart_pkg::*;
(
  input  logic [2:0] req,
  input  logic       force_cpu,
  output logic [1:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = REQ_CPU;
    valid = |req;
    priority case (1'b1)
      force_cpu && req[REQ_CPU]: idx = REQ_CPU;
      req[REQ_OAM]:              idx = REQ_OAM;
      req[REQ_HDMA]:             idx = REQ_HDMA;
      default:                   idx = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/cart_bus_arb.sv
// Three-requester arbiter and access sequencer for the cart bus.
// One strobe per access, wait for busy to drop, then one-cycle ack.
module cart_bus_arb
  import cart_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_8m,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [47:0] addr,
  input  logic [23:0] wdata,
  output logic [2:0]  ack,
  output logic [7:0]  rdata,
  output logic [15:0] m_addr,
  output logic [7:0]  m_din,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [7:0]  m_dout,
  input  logic        m_busy
);

  state_t           state, state_d;
  logic [1:0]       win, win_d;
  logic             wr_q, wr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       ack_d;
  logic [7:0]       rdata_d;
  logic [15:0]      m_addr_d;
  logic [7:0]       m_din_d;
  logic             m_rd_d, m_wr_d;

  logic [1:0]       pick_idx;
  logic             pick_valid;
  logic             force_cpu;
  logic [15:0]      sel_addr;
  logic [7:0]       sel_din;
  logic             sel_we;

  assign force_cpu = (cnt == CNT_W'(STARVE_LIMIT));

  cart_arb_pick u_pick (
    .req       (req),
    .force_cpu (force_cpu),
    .idx       (pick_idx),
    .valid     (pick_valid)
  );

  always_comb begin
    sel_addr = addr[15:0];
    sel_din  = wdata[7:0];
    sel_we   = we[REQ_CPU];
    case (pick_idx)
      REQ_HDMA: begin
        sel_addr = addr[31:16];
        sel_din  = wdata[15:8];
        sel_we   = we[REQ_HDMA];
      end
      REQ_OAM: begin
        sel_addr = addr[47:32];
        sel_din  = wdata[23:16];
        sel_we   = we[REQ_OAM];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state;
    win_d    = win;
    wr_d     = wr_q;
    cnt_d    = cnt;
    ack_d    = '0;
    rdata_d  = rdata;
    m_addr_d = m_addr;
    m_din_d  = m_din;
    m_rd_d   = 1'b0;
    m_wr_d   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!req[REQ_CPU]) cnt_d = '0;
        if (pick_valid) begin
          state_d  = ST_ISSUE;
          win_d    = pick_idx;
          wr_d     = sel_we;
          m_addr_d = sel_addr;
          m_din_d  = sel_din;
          m_rd_d   = !sel_we;
          m_wr_d   = sel_we;
          // only DMA wins that overtake a waiting CPU count
          if (pick_idx != REQ_CPU && req[REQ_CPU])
            cnt_d = cnt + 1'b1;
          else
            cnt_d = '0;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!m_busy) begin
          if (!wr_q) rdata_d = m_dout;
          ack_d   = onehot(win);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      state  <= ST_IDLE;
      win    <= REQ_CPU;
      wr_q   <= 1'b0;
      cnt    <= '0;
      ack    <= '0;
      rdata  <= 8'hFF;
      m_addr <= '0;
      m_din  <= '0;
      m_rd   <= 1'b0;
      m_wr   <= 1'b0;
    end else begin
      state  <= state_d;
      win    <= win_d;
      wr_q   <= wr_d;
      cnt    <= cnt_d;
      ack    <= ack_d;
      rdata  <= rdata_d;
      m_addr <= m_addr_d;
      m_din  <= m_din_d;
      m_rd   <= m_rd_d;
      m_wr   <= m_wr_d;
    end
  end

endmodule

// File: tb/tb_cart_bus_arb.sv
// Scoreboard bench for cart_bus_arb with a cart memory model.
// Directed scenarios followed by randomized three-requester traffic.
module tb_cart_bus_arb;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  we = '0;
  logic [47:0] addr = '0;
  logic [23:0] wdata = '0;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic [15:0] m_addr;
  logic [7:0]  m_din;
  logic        m_rd, m_wr;
  logic [7:0]  m_dout;
  logic        m_busy;

  always #5 clk = ~clk;

  cart_bus_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_8m (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .ack    (ack),
    .rdata  (rdata),
    .m_addr (m_addr),
    .m_din  (m_din),
    .m_rd   (m_rd),
    .m_wr   (m_wr),
    .m_dout (m_dout),
    .m_busy (m_busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'h0150) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // cart interface: busy for lat cycles counted from the strobe edge
  logic [7:0] cart_mem [int];
  int         busy_cnt = 0;
  logic [7:0] dout_q = 8'h00;
  int         lat_fix = 4;
  int         rnd_lat = 3;
  int         lat_eff;

  always_comb lat_eff = (lat_fix != 0) ? lat_fix : rnd_lat;

  always @(posedge clk) begin
    if (rst) begin
      busy_cnt <= 0;
      dout_q   <= 8'h00;
    end else if (m_rd || m_wr) begin
      busy_cnt <= lat_eff - 1;
      rnd_lat  <= $urandom_range(1, 6);
      if (m_wr)
        cart_mem[int'(m_addr)] = m_din;
      else
        dout_q <= cart_mem.exists(int'(m_addr)) ?
                  cart_mem[int'(m_addr)] : init_val(m_addr);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  assign m_busy = m_rd | m_wr | (busy_cnt != 0);
  assign m_dout = m_busy ? 8'hEE : dout_q;

  // reference model and scoreboard
  typedef struct {
    int          idx;
    bit          w;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  rd;
    int          ack_cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] ref_mem [int];
  logic [7:0] last_rd = 8'hFF;
  int         ack_log[$];
  int         cyc = 0;
  int         idle_from = 0;
  int         scnt = 0;
  int         w_idx;
  int         last_ack_cyc = 0;
  int         last_strobe_cyc = 0;
  bit         grant;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      sb.delete();
      idle_from = cyc + 1;
      scnt = 0;
      last_rd = 8'hFF;
    end else begin
      if (ack != 0) begin
        if (sb.size() == 0) begin
          check("spurious_ack", ack, 0);
        end else begin
          e = sb.pop_front();
          check("ack_bits", ack, 3'b001 << e.idx);
          check("ack_cycle", cyc, e.ack_cyc);
          check("rdata", rdata, e.rd);
          last_rd = e.rd;
          ack_log.push_back(e.idx);
          last_ack_cyc = cyc;
          idle_from = cyc + 2;
        end
      end else if (sb.size() != 0 && cyc >= sb[0].ack_cyc) begin
        check("ack_missing", ack, 3'b001 << sb[0].idx);
        void'(sb.pop_front());
        idle_from = cyc + 1;
      end

      grant = (sb.size() == 0) && (cyc >= idle_from) && (req != 0);
      if (sb.size() == 0 && cyc >= idle_from && !req[0]) scnt = 0;
      if (grant) begin
        if (req[0] && scnt == LIMIT) w_idx = 0;
        else if (req[2]) w_idx = 2;
        else if (req[1]) w_idx = 1;
        else w_idx = 0;
        e.idx = w_idx;
        e.w = we[w_idx];
        e.a = addr[16*w_idx +: 16];
        e.d = wdata[8*w_idx +: 8];
        check("strobe_rd", m_rd, !e.w);
        check("strobe_wr", m_wr, e.w);
        check("m_addr", m_addr, e.a);
        if (e.w) begin
          check("m_din", m_din, e.d);
          ref_mem[int'(e.a)] = e.d;
          e.rd = last_rd;
        end else begin
          e.rd = ref_mem.exists(int'(e.a)) ?
                 ref_mem[int'(e.a)] : init_val(e.a);
        end
        e.ack_cyc = cyc + lat_eff + 1;
        if (w_idx == 0 || !req[0]) scnt = 0;
        else scnt++;
        last_strobe_cyc = cyc;
        sb.push_back(e);
      end else if (m_rd || m_wr) begin
        check("spurious_strobe", {m_rd, m_wr}, 0);
      end
    end
  end

  task automatic access(input int i, input bit w, input logic [15:0] a,
                        input logic [7:0] d, input bit keep);
    bit got;
    got = 1'b0;
    we[i] = w;
    addr[16*i +: 16] = a;
    wdata[8*i +: 8] = d;
    req[i] = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ack[i]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: requester %0d got no ack", i);
    end
    if (!keep) begin
      req[i] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic rand_agent(input int i, input int n);
    bit keep;
    for (int k = 0; k < n; k++) begin
      keep = (k != n - 1) && ($urandom_range(0, 1) == 1);
      if (!req[i]) repeat ($urandom_range(0, 4)) @(negedge clk);
      access(i, $urandom_range(0, 1) == 1,
             16'h4000 + 16'($urandom_range(0, 7)), 8'($urandom), keep);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ord[7];
    int a1;
    bit saw;
    exp_ord = '{2, 2, 2, 2, 0, 2, 2};

    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_m_rd", m_rd, 0);
    check("rst_m_wr", m_wr, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_din", m_din, 0);
    check("rst_rdata", rdata, 8'hFF);
    rst = 1'b0;
    @(negedge clk);

    access(0, 1'b0, 16'h0150, 8'h00, 1'b0);
    check("cpu_rd_data", rdata, 8'h3C);
    check("cpu_rd_latency", last_ack_cyc - last_strobe_cyc, 5);

    access(0, 1'b1, 16'h2000, 8'h05, 1'b0);
    check("cpu_wr_rdata_held", rdata, 8'h3C);
    access(0, 1'b0, 16'h2000, 8'h00, 1'b0);
    check("cpu_wr_readback", rdata, 8'h05);

    repeat (2) @(negedge clk);
    ack_log.delete();
    fork
      access(0, 1'b0, 16'h4001, 8'h00, 1'b0);
      access(1, 1'b1, 16'h4002, 8'h77, 1'b0);
      access(2, 1'b0, 16'h4002, 8'h00, 1'b0);
    join
    check("prio_count", ack_log.size(), 3);
    check("prio_first", ack_log.size() > 0 ? ack_log[0] : 9, 2);
    check("prio_second", ack_log.size() > 1 ? ack_log[1] : 9, 1);
    check("prio_third", ack_log.size() > 2 ? ack_log[2] : 9, 0);

    repeat (2) @(negedge clk);
    ack_log.delete();
    fork
      begin
        for (int n = 0; n < 6; n++)
          access(2, 1'b0, 16'h4000 + 16'(n), 8'h00, n != 5);
      end
      access(0, 1'b0, 16'h4003, 8'h00, 1'b0);
    join
    check("starve_count", ack_log.size(), 7);
    for (int k = 0; k < 7; k++)
      check("starve_order", k < ack_log.size() ? ack_log[k] : 9,
            exp_ord[k]);

    repeat (2) @(negedge clk);
    ack_log.delete();
    access(0, 1'b0, 16'h4005, 8'h00, 1'b0);
    a1 = last_ack_cyc;
    access(0, 1'b1, 16'h4006, 8'h99, 1'b0);
    check("rereq_gap", last_strobe_cyc - a1, 2);
    check("rereq_no_dup", ack_log.size(), 2);

    lat_fix = 6;
    saw = 1'b0;
    we[0] = 1'b0;
    addr[15:0] = 16'h0300;
    req[0] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (m_rd) begin
        saw = 1'b1;
        break;
      end
    end
    check("rst_test_strobe", saw, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ack", ack, 0);
    check("midrst_m_rd", m_rd, 0);
    check("midrst_m_wr", m_wr, 0);
    check("midrst_m_addr", m_addr, 0);
    check("midrst_m_din", m_din, 0);
    check("midrst_rdata", rdata, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    lat_fix = 4;
    access(0, 1'b0, 16'h0150, 8'h00, 1'b0);
    check("post_rst_read", rdata, 8'h3C);

    lat_fix = 0;
    fork
      rand_agent(0, 40);
      rand_agent(1, 40);
      rand_agent(2, 40);
    join
    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
